// File: rtl/drum_timing_gen_if.sv
// Drum timing bus: bit-time controls in, counters and decoded strobes out.
interface drum_timing_gen_if #(
   parameter int unsigned BT_W = 5,
   parameter int unsigned WT_W = 7,
   parameter int unsigned WS_W = 2
);
   logic            BIT_EN;
   logic            RESYNC;
   logic            HOLD;
   logic [BT_W-1:0] BT;
   logic [WT_W-1:0] WT;
   logic [WS_W-1:0] WS;
   logic            T0;
   logic            T1;
   logic            T13;
   logic            T21;
   logic            T28;
   logic            TE;
   logic            REV;
   logic            SYNC_ACK;

   // Controller side: drives the bit-time controls, consumes timing
   modport master (
      output BIT_EN, RESYNC, HOLD,
      input  BT, WT, WS, T0, T1, T13, T21, T28, TE, REV, SYNC_ACK
   );

   // Timing generator side
   modport slave (
      input  BIT_EN, RESYNC, HOLD,
      output BT, WT, WS, T0, T1, T13, T21, T28, TE, REV, SYNC_ACK
   );
endinterface

// File: rtl/drum_timing_gen.sv
// G-15 drum timing: bit-time / word-time counters with registered strobe decode
// and a latched resync request that realigns to word 0, bit 0.
module drum_timing_gen #(
   parameter int unsigned WORD_BITS   = 29,
   parameter int unsigned LONG_WORDS  = 108,
   parameter int unsigned SHORT_WORDS = 4
) (
   input  logic                CLOCK,
   input  logic                rst,
   drum_timing_gen_if.slave    bus
);

   localparam int unsigned BT_W = $clog2(WORD_BITS);
   localparam int unsigned WT_W = $clog2(LONG_WORDS);
   localparam int unsigned WS_W = $clog2(SHORT_WORDS);

   localparam logic [BT_W-1:0] BT_LAST = BT_W'(WORD_BITS - 1);
   localparam logic [WT_W-1:0] WT_LAST = WT_W'(LONG_WORDS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [BT_W-1:0] bt_q, bt_d;
   logic [WT_W-1:0] wt_q, wt_d;
   logic [WS_W-1:0] ws_q, ws_d;
   logic            t0_q, t0_d;
   logic            t1_q, t1_d;
   logic            t13_q, t13_d;
   logic            t21_q, t21_d;
   logic            t28_q, t28_d;
   logic            te_q, te_d;
   logic            rev_q, rev_d;
   logic            sync_ack_q, sync_ack_d;

   // Next-state: resync FSM, counter advance, and strobe decode of the next count
   always_comb begin
      state_d    = state_q;
      bt_d       = bt_q;
      wt_d       = wt_q;
      sync_ack_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.RESYNC) begin
               state_d = PEND;
            end
            if (bus.BIT_EN && !bus.HOLD) begin
               // Out-of-range values also fall into the wrap/clear paths
               if (bt_q >= BT_LAST) begin
                  bt_d = '0;
                  wt_d = (wt_q >= WT_LAST) ? '0 : wt_q + WT_W'(1);
               end else begin
                  bt_d = bt_q + BT_W'(1);
                  if (wt_q > WT_LAST) begin
                     wt_d = '0;
                  end
               end
            end
         end
         PEND: begin
            // Load overrides HOLD; a RESYNC on this edge is absorbed
            if (bus.BIT_EN) begin
               bt_d       = '0;
               wt_d       = '0;
               sync_ack_d = 1'b1;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ws_d  = WS_W'(wt_d % WT_W'(SHORT_WORDS));
      t0_d  = (bt_d == '0);
      t1_d  = (bt_d == BT_W'(1));
      t13_d = (bt_d == BT_W'(13));
      t21_d = (bt_d == BT_W'(21));
      t28_d = (bt_d == BT_LAST);
      te_d  = ~wt_d[0];
      rev_d = (bt_d == BT_LAST) && (wt_d == WT_LAST);
   end

   // State, counters and strobes; reset leaves word 0, bit 0 decoded
   always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         bt_q       <= '0;
         wt_q       <= '0;
         ws_q       <= '0;
         t0_q       <= 1'b1;
         t1_q       <= 1'b0;
         t13_q      <= 1'b0;
         t21_q      <= 1'b0;
         t28_q      <= 1'b0;
         te_q       <= 1'b1;
         rev_q      <= 1'b0;
         sync_ack_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bt_q       <= bt_d;
         wt_q       <= wt_d;
         ws_q       <= ws_d;
         t0_q       <= t0_d;
         t1_q       <= t1_d;
         t13_q      <= t13_d;
         t21_q      <= t21_d;
         t28_q      <= t28_d;
         te_q       <= te_d;
         rev_q      <= rev_d;
         sync_ack_q <= sync_ack_d;
      end
   end

   assign bus.BT       = bt_q;
   assign bus.WT       = wt_q;
   assign bus.WS       = ws_q;
   assign bus.T0       = t0_q;
   assign bus.T1       = t1_q;
   assign bus.T13      = t13_q;
   assign bus.T21      = t21_q;
   assign bus.T28      = t28_q;
   assign bus.TE       = te_q;
   assign bus.REV      = rev_q;
   assign bus.SYNC_ACK = sync_ack_q;

endmodule

// File: tb/tb_drum_timing_gen.sv
// Bench for drum_timing_gen: directed scenarios plus random traffic against
// an absolute-position model of the drum (pos = word*29 + bit).
module tb_drum_timing_gen;

   localparam int unsigned WB      = 29;
   localparam int unsigned LW      = 108;
   localparam int unsigned REV_LEN = WB * LW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   drum_timing_gen_if bus ();

   drum_timing_gen dut (
      .CLOCK (clk),
      .rst   (rst),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: position on the drum, pending flag, expected ack
   int pos  = 0;
   bit pend = 1'b0;
   bit ack_exp = 1'b0;

   function automatic void model_reset();
      pos     = 0;
      pend    = 1'b0;
      ack_exp = 1'b0;
   endfunction

   function automatic void model_edge(input bit en, input bit rs, input bit hd);
      ack_exp = 1'b0;
      if (pend && en) begin
         pos     = 0;
         pend    = 1'b0;
         ack_exp = 1'b1;
      end else begin
         if (en && !hd) pos = (pos + 1) % REV_LEN;
         if (rs) pend = 1'b1;
      end
   endfunction

   // {BT, WT, WS, T0, T1, T13, T21, T28, TE, REV, SYNC_ACK}
   function automatic logic [21:0] exp_vec();
      int bt = pos % WB;
      int wt = pos / WB;
      return {5'(bt), 7'(wt), 2'(wt % 4), bt == 0, bt == 1, bt == 13, bt == 21,
              bt == WB - 1, (wt % 2) == 0, pos == REV_LEN - 1, ack_exp};
   endfunction

   function automatic logic [21:0] act_vec();
      return {bus.BT, bus.WT, bus.WS, bus.T0, bus.T1, bus.T13, bus.T21,
              bus.T28, bus.TE, bus.REV, bus.SYNC_ACK};
   endfunction

   // One clock edge with the given controls; returns #1 after the edge
   task automatic tick(input bit en, input bit rs, input bit hd);
      bus.BIT_EN = en;
      bus.RESYNC = rs;
      bus.HOLD   = hd;
      @(posedge clk);
      if (!rst) model_edge(en, rs, hd);
      #1;
      bus.BIT_EN = 1'b0;
      bus.RESYNC = 1'b0;
      bus.HOLD   = 1'b0;
   endtask

   task automatic test_reset();
      logic [21:0] a, e;
      rst = 1'b1;
      bus.BIT_EN = 1'b0; bus.RESYNC = 1'b0; bus.HOLD = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      a = act_vec(); e = exp_vec();
      checks++;
      if (a !== e) begin failures++; $display("FAIL reset_values act=%h exp=%h", a, e); end
      rst = 1'b0;
      repeat (55 * WB + 17) tick(1, 0, 0);
      checks++;
      if (bus.BT !== 5'd17 || bus.WT !== 7'd55) begin
         failures++; $display("FAIL reach_17_55 act=%0d/%0d exp=17/55", bus.BT, bus.WT);
      end
      #1 rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if (bus.BT !== 5'd0 || bus.WT !== 7'd0 || bus.T0 !== 1'b1 || bus.TE !== 1'b1 ||
          bus.SYNC_ACK !== 1'b0 || bus.WS !== 2'd0 || bus.REV !== 1'b0) begin
         failures++; $display("FAIL async_reset act=%h exp=%h", act_vec(), exp_vec());
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_free_run();
      int t0_cnt = 0;
      int rev_cnt = 0;
      logic [21:0] a, e;
      for (int i = 0; i < int'(REV_LEN); i++) begin
         tick(1, 0, 0);
         a = act_vec(); e = exp_vec();
         checks++;
         if (a !== e) begin failures++; $display("FAIL free_run[%0d] act=%h exp=%h", i, a, e); end
         if (bus.T0 === 1'b1) t0_cnt++;
         if (bus.REV === 1'b1) rev_cnt++;
      end
      checks++;
      if (t0_cnt !== 108) begin failures++; $display("FAIL t0_count act=%0d exp=108", t0_cnt); end
      checks++;
      if (rev_cnt !== 1) begin failures++; $display("FAIL rev_count act=%0d exp=1", rev_cnt); end
      checks++;
      if (bus.BT !== 5'd0 || bus.WT !== 7'd0) begin
         failures++; $display("FAIL free_run_wrap act=%0d/%0d exp=0/0", bus.BT, bus.WT);
      end
   endtask

   task automatic test_gapped();
      logic [21:0] a, e;
      for (int k = 0; k < 100; k++) begin
         tick(1, 0, 0);
         for (int g = 0; g < 2; g++) begin
            tick(0, 0, 0);
            a = act_vec(); e = exp_vec();
            checks++;
            if (a !== e) begin failures++; $display("FAIL gapped_idle[%0d] act=%h exp=%h", k, a, e); end
         end
      end
      checks++;
      if (bus.BT !== 5'd13 || bus.WT !== 7'd3 || bus.WS !== 2'd3 ||
          bus.T13 !== 1'b1 || bus.TE !== 1'b0) begin
         failures++; $display("FAIL gapped_final act=%h exp=BT13 WT3 WS3 T13 TE0", act_vec());
      end
   endtask

   task automatic test_hold();
      logic [21:0] a, e;
      repeat (9 * WB + 20 - 100) tick(1, 0, 0);
      repeat (10) tick(1, 0, 1);
      a = act_vec(); e = exp_vec();
      checks++;
      if (bus.BT !== 5'd20 || bus.WT !== 7'd9 || a !== e) begin
         failures++; $display("FAIL hold_frozen act=%h exp=%h", a, e);
      end
      tick(1, 0, 0);
      checks++;
      if (bus.BT !== 5'd21 || bus.T21 !== 1'b1) begin
         failures++; $display("FAIL hold_release act=%0d/%b exp=21/1", bus.BT, bus.T21);
      end
   endtask

   task automatic test_resync();
      logic [21:0] a, e;
      int acks;
      repeat (40 * WB + 5 - (9 * WB + 21)) tick(1, 0, 0);
      checks++;
      if (bus.BT !== 5'd5 || bus.WT !== 7'd40) begin
         failures++; $display("FAIL reach_5_40 act=%0d/%0d exp=5/40", bus.BT, bus.WT);
      end
      tick(0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         tick(0, 0, 0);
         a = act_vec(); e = exp_vec();
         checks++;
         if (a !== e) begin failures++; $display("FAIL resync_wait[%0d] act=%h exp=%h", i, a, e); end
      end
      tick(1, 0, 0);
      checks++;
      if (bus.BT !== 5'd0 || bus.WT !== 7'd0 || bus.SYNC_ACK !== 1'b1) begin
         failures++; $display("FAIL resync_load act=%h exp=BT0 WT0 ACK1", act_vec());
      end
      tick(0, 0, 0);
      checks++;
      if (bus.SYNC_ACK !== 1'b0) begin failures++; $display("FAIL ack_one_cycle act=1 exp=0"); end

      // Double request while pending, load under HOLD with RESYNC absorbed
      repeat (7) tick(1, 0, 0);
      tick(0, 1, 0);
      tick(0, 1, 0);
      tick(1, 1, 1);
      a = act_vec(); e = exp_vec();
      checks++;
      if (a !== e || bus.SYNC_ACK !== 1'b1 || bus.BT !== 5'd0) begin
         failures++; $display("FAIL resync_hold_load act=%h exp=%h", a, e);
      end
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1, 0, 0);
         if (bus.SYNC_ACK === 1'b1) acks++;
      end
      checks++;
      if (acks !== 0 || bus.BT !== 5'd6) begin
         failures++; $display("FAIL second_ack act=%0d acks bt=%0d exp=0 acks bt=6", acks, bus.BT);
      end

      // Simultaneous BIT_EN and RESYNC in IDLE: advance now, load on next enable
      tick(1, 1, 0);
      a = act_vec(); e = exp_vec();
      checks++;
      if (a !== e || bus.BT !== 5'd7) begin failures++; $display("FAIL en_rs_idle act=%h exp=%h", a, e); end
      tick(1, 0, 0);
      a = act_vec(); e = exp_vec();
      checks++;
      if (a !== e || bus.SYNC_ACK !== 1'b1) begin
         failures++; $display("FAIL en_rs_load act=%h exp=%h", a, e);
      end
   endtask

   task automatic test_reset_pend();
      int acks = 0;
      repeat (3) tick(1, 0, 0);
      tick(0, 1, 0);
      #1 rst = 1'b1;
      #1 model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 0);
         if (bus.SYNC_ACK === 1'b1) acks++;
      end
      tick(1, 0, 0);
      if (bus.SYNC_ACK === 1'b1) acks++;
      checks++;
      if (bus.BT !== 5'd1 || bus.WT !== 7'd0) begin
         failures++; $display("FAIL reset_pend_first_en act=%0d/%0d exp=1/0", bus.BT, bus.WT);
      end
      repeat (3) begin
         tick(1, 0, 0);
         if (bus.SYNC_ACK === 1'b1) acks++;
      end
      checks++;
      if (acks !== 0) begin failures++; $display("FAIL reset_pend_ack act=%0d exp=0", acks); end
   endtask

   task automatic test_random();
      logic [21:0] a, e;
      bit en, rs, hd;
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom % 2) == 0;
         rs = ($urandom % 16) == 0;
         hd = ($urandom % 5) == 0;
         tick(en, rs, hd);
         a = act_vec(); e = exp_vec();
         checks++;
         if (a !== e) begin failures++; $display("FAIL random[%0d] act=%h exp=%h", i, a, e); end
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_gapped();
      test_hold();
      test_resync();
      test_reset_pend();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
